pbvi_step4_converge: RTL and testbench

- Downstream of the step3 action-selection stage in the PBVI pipeline. It consumes the per-belief-point alpha vectors and chosen actions that step3 produces.
- Evaluates the value function at every belief point, one point per cycle, and compares it with the previous iteration's values.
- Decides either to stop (converged or iteration cap reached) or to restart the next value-iteration loop.
- Holds the committed alpha set and policy for the rest of the design.

---
 rtl/pbvi_step4_converge_pkg.sv | 27 ++
 rtl/pbvi_step4_converge_dot2.sv | 21 ++
 rtl/pbvi_step4_converge.sv | 165 ++++++++++++++++
 tb/tb_pbvi_step4_converge.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pbvi_step4_converge_pkg.sv
// Shared types and constants for the PBVI pipeline stages.
package pbvi_pkg;

    localparam int NPOINT = 16;
    localparam int NSTATE = 2;
    localparam int W      = 16;
    localparam int VW     = 17;
    localparam int IW     = 8;
    localparam int IDXW   = $clog2(NPOINT);

    typedef logic [W-1:0]  belief_t;
    typedef logic [W-1:0]  alpha_t;
    typedef logic [1:0]    action_t;
    typedef logic [VW-1:0] value_t;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DECIDE
    } state_e;

    // Magnitude of the change between two unsigned values.
    function automatic value_t absDiff(input value_t a, input value_t b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/pbvi_step4_converge_dot2.sv
// Two-term belief/alpha dot product scaled back by 2^16 (Q0.16 belief).
module pbvi_dot2
    import pbvi_pkg::*;
(
    input  alpha_t  a0_i,
    input  alpha_t  a1_i,
    input  belief_t b0_i,
    input  belief_t b1_i,
    output value_t  v_o
);

    logic [2*W-1:0] prod0;
    logic [2*W-1:0] prod1;
    logic [2*W:0]   sum;

    assign prod0 = a0_i * b0_i;
    assign prod1 = a1_i * b1_i;
    assign sum   = {1'b0, prod0} + {1'b0, prod1};
    assign v_o   = sum[2*W:W];

endmodule

// File: rtl/pbvi_step4_converge.sv
// Convergence stage: evaluates V at each belief point, tracks the largest
// change from the previous pass and either finishes or requests another loop.
module pbvi_step4_converge
    import pbvi_pkg::*;
#(
    parameter value_t      EPS      = 17'h00010,
    parameter int unsigned MAX_ITER = 255
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               en_i,
    input  alpha_t  [NPOINT-1:0][NSTATE-1:0]   alpha_i,
    input  belief_t [NPOINT-1:0][NSTATE-1:0]   point_belief_i,
    input  action_t [NPOINT-1:0]               point_action_i,
    output alpha_t  [NPOINT-1:0][NSTATE-1:0]   alpha_set_o,
    output action_t [NPOINT-1:0]               policy_o,
    output logic                               busy_o,
    output logic                               loop_start_o,
    output logic                               done_o,
    output logic                               converged_o,
    output logic    [IW-1:0]                   iter_count_o,
    output value_t                             max_diff_o
);

    state_e                             state_q, state_d;
    logic    [IDXW-1:0]                 idx_q, idx_d;
    value_t                             maxAcc_q, maxAcc_d;
    value_t  [NPOINT-1:0]               vPrev_q, vPrev_d;
    logic                               prevValid_q, prevValid_d;
    alpha_t  [NPOINT-1:0][NSTATE-1:0]   shAlpha_q, shAlpha_d;
    belief_t [NPOINT-1:0][NSTATE-1:0]   shBelief_q, shBelief_d;
    action_t [NPOINT-1:0]               shAction_q, shAction_d;
    alpha_t  [NPOINT-1:0][NSTATE-1:0]   alphaSet_q, alphaSet_d;
    action_t [NPOINT-1:0]               policy_q, policy_d;
    logic                               loopStart_q, loopStart_d;
    logic                               done_q, done_d;
    logic                               converged_q, converged_d;
    logic    [IW-1:0]                   iter_q, iter_d;
    value_t                             maxDiff_q, maxDiff_d;

    value_t                             vCur;
    value_t                             dAbs;
    logic    [IW-1:0]                   iterNext;

    pbvi_dot2 uDot (
        .a0_i (shAlpha_q[idx_q][0]),
        .a1_i (shAlpha_q[idx_q][1]),
        .b0_i (shBelief_q[idx_q][0]),
        .b1_i (shBelief_q[idx_q][1]),
        .v_o  (vCur)
    );

    assign dAbs = absDiff(vCur, vPrev_q[idx_q]);

    // Next-state and output decisions; pulses default low every cycle.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        maxAcc_d    = maxAcc_q;
        vPrev_d     = vPrev_q;
        prevValid_d = prevValid_q;
        shAlpha_d   = shAlpha_q;
        shBelief_d  = shBelief_q;
        shAction_d  = shAction_q;
        alphaSet_d  = alphaSet_q;
        policy_d    = policy_q;
        loopStart_d = 1'b0;
        done_d      = 1'b0;
        converged_d = converged_q;
        iter_d      = iter_q;
        maxDiff_d   = maxDiff_q;
        iterNext    = (iter_q == {IW{1'b1}}) ? iter_q : iter_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (en_i) begin
                    shAlpha_d   = alpha_i;
                    shBelief_d  = point_belief_i;
                    shAction_d  = point_action_i;
                    idx_d       = '0;
                    maxAcc_d    = '0;
                    converged_d = 1'b0;
                    state_d     = EVAL;
                end
            end
            EVAL: begin
                vPrev_d[idx_q] = vCur;
                if (dAbs > maxAcc_q) begin
                    maxAcc_d = dAbs;
                end
                if (idx_q == IDXW'(NPOINT - 1)) begin
                    state_d = DECIDE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DECIDE: begin
                iter_d      = iterNext;
                maxDiff_d   = maxAcc_q;
                alphaSet_d  = shAlpha_q;
                policy_d    = shAction_q;
                prevValid_d = 1'b1;
                if (prevValid_q && (maxAcc_q <= EPS)) begin
                    done_d      = 1'b1;
                    converged_d = 1'b1;
                end else if (iterNext == IW'(MAX_ITER)) begin
                    done_d = 1'b1;
                end else begin
                    loopStart_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset discards any in-flight pass without committing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            maxAcc_q    <= '0;
            vPrev_q     <= '0;
            prevValid_q <= 1'b0;
            shAlpha_q   <= '0;
            shBelief_q  <= '0;
            shAction_q  <= '0;
            alphaSet_q  <= '0;
            policy_q    <= '0;
            loopStart_q <= 1'b0;
            done_q      <= 1'b0;
            converged_q <= 1'b0;
            iter_q      <= '0;
            maxDiff_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            maxAcc_q    <= maxAcc_d;
            vPrev_q     <= vPrev_d;
            prevValid_q <= prevValid_d;
            shAlpha_q   <= shAlpha_d;
            shBelief_q  <= shBelief_d;
            shAction_q  <= shAction_d;
            alphaSet_q  <= alphaSet_d;
            policy_q    <= policy_d;
            loopStart_q <= loopStart_d;
            done_q      <= done_d;
            converged_q <= converged_d;
            iter_q      <= iter_d;
            maxDiff_q   <= maxDiff_d;
        end
    end

    assign alpha_set_o  = alphaSet_q;
    assign policy_o     = policy_q;
    assign busy_o       = (state_q != IDLE);
    assign loop_start_o = loopStart_q;
    assign done_o       = done_q;
    assign converged_o  = converged_q;
    assign iter_count_o = iter_q;
    assign max_diff_o   = maxDiff_q;

endmodule

// File: tb/tb_pbvi_step4_converge.sv
// Directed bench for the convergence stage, with a second instance whose
// iteration cap is lowered to exercise the cap path.
module tb_pbvi_step4_converge;
    import pbvi_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic enCap;

    alpha_t  [NPOINT-1:0][NSTATE-1:0] alpha;
    alpha_t  [NPOINT-1:0][NSTATE-1:0] alphaCap;
    belief_t [NPOINT-1:0][NSTATE-1:0] belief;
    action_t [NPOINT-1:0]             action;

    alpha_t  [NPOINT-1:0][NSTATE-1:0] alphaSet, alphaSetCap;
    action_t [NPOINT-1:0]             policy, policyCap;
    logic busy, loopStart, done, converged;
    logic busyCap, loopStartCap, doneCap, convergedCap;
    logic   [IW-1:0] iterCount, iterCountCap;
    value_t          maxDiff, maxDiffCap;

    alpha_t  [NPOINT-1:0][NSTATE-1:0] baseAlpha, modAlpha, capAlpha1, capAlpha2, capAlpha3;
    action_t [NPOINT-1:0]             baseAction;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pbvi_step4_converge dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .en_i           (en),
        .alpha_i        (alpha),
        .point_belief_i (belief),
        .point_action_i (action),
        .alpha_set_o    (alphaSet),
        .policy_o       (policy),
        .busy_o         (busy),
        .loop_start_o   (loopStart),
        .done_o         (done),
        .converged_o    (converged),
        .iter_count_o   (iterCount),
        .max_diff_o     (maxDiff)
    );

    pbvi_step4_converge #(.MAX_ITER(3)) dutCap (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .en_i           (enCap),
        .alpha_i        (alphaCap),
        .point_belief_i (belief),
        .point_action_i (action),
        .alpha_set_o    (alphaSetCap),
        .policy_o       (policyCap),
        .busy_o         (busyCap),
        .loop_start_o   (loopStartCap),
        .done_o         (doneCap),
        .converged_o    (convergedCap),
        .iter_count_o   (iterCountCap),
        .max_diff_o     (maxDiffCap)
    );

    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Starts one pass from a negedge and returns at the negedge right after
    // the edge that makes the end-of-pass pulse visible (edge k+17).
    task automatic applyStimulus(input bit useCap, input logic [511:0] a,
                                 input logic [31:0] act, input bit scramble);
        if (useCap) begin
            alphaCap = a;
            enCap    = 1'b1;
        end else begin
            alpha  = a;
            action = act;
            en     = 1'b1;
        end
        @(negedge clk);
        en    = 1'b0;
        enCap = 1'b0;
        if (scramble) begin
            alpha  = ~a;
            action = ~act;
        end
        @(negedge clk);
        checkOutput("busyDuringEval", useCap ? busyCap : busy, 1);
        repeat (15) @(negedge clk);
        checkOutput("noEarlyPulse", useCap ? {loopStartCap, doneCap} : {loopStart, done}, 0);
        checkOutput("busyInDecide", useCap ? busyCap : busy, 1);
        @(negedge clk);
        checkOutput("idleAfterPass", useCap ? busyCap : busy, 0);
    endtask

    initial begin
        for (int i = 0; i < NPOINT; i++) begin
            baseAlpha[i][0]  = 16'h1000;
            baseAlpha[i][1]  = 16'h1000;
            capAlpha1[i][0]  = 16'h1000;
            capAlpha1[i][1]  = 16'h1000;
            capAlpha2[i][0]  = 16'h2000;
            capAlpha2[i][1]  = 16'h2000;
            capAlpha3[i][0]  = 16'h3000;
            capAlpha3[i][1]  = 16'h3000;
            belief[i][0]     = 16'(i * 16'h1000);
            belief[i][1]     = 16'(16'hffff - i * 16'h1000);
            baseAction[i]    = 2'(i % 4);
        end
        modAlpha       = baseAlpha;
        modAlpha[5][0] = 16'h2000;
        alpha    = baseAlpha;
        alphaCap = baseAlpha;
        action   = baseAction;
        en       = 1'b0;
        enCap    = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstFlags", {busy, loopStart, done, converged}, 0);
        checkOutput("rstIter", iterCount, 0);
        checkOutput("rstMaxDiff", maxDiff, 0);
        checkOutput("rstAlphaSet", alphaSet, 0);
        checkOutput("rstPolicy", policy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // First pass never converges: V=0x0FFF everywhere versus zero history.
        applyStimulus(0, baseAlpha, baseAction, 0);
        checkOutput("p1LoopDone", {loopStart, done, converged}, 3'b100);
        checkOutput("p1Iter", iterCount, 1);
        checkOutput("p1MaxDiff", maxDiff, 17'h00FFF);

        // Identical second pass converges; inputs scrambled after en must not matter.
        applyStimulus(0, baseAlpha, baseAction, 1);
        checkOutput("p2LoopDone", {loopStart, done, converged}, 3'b011);
        checkOutput("p2Iter", iterCount, 2);
        checkOutput("p2MaxDiff", maxDiff, 0);
        checkOutput("p2AlphaSet", alphaSet, baseAlpha);
        checkOutput("p2Policy", policy, baseAction);
        @(negedge clk);
        checkOutput("p2ConvHold", {done, converged}, 2'b01);

        // Point 5 changes to V=0x14FF: diff 0x500 above threshold.
        applyStimulus(0, modAlpha, baseAction, 0);
        checkOutput("p3LoopDone", {loopStart, done, converged}, 3'b100);
        checkOutput("p3Iter", iterCount, 3);
        checkOutput("p3MaxDiff", maxDiff, 17'h00500);
        checkOutput("p3AlphaSet", alphaSet, modAlpha);

        // en held for 40 cycles: passes restart every 18 cycles.
        alpha = baseAlpha;
        en    = 1'b1;
        for (int i = 1; i <= 56; i++) begin
            @(negedge clk);
            if (i == 40) en = 1'b0;
            if (i == 17 || i == 35) checkOutput("holdNoPulse", {loopStart, done}, 0);
            if (i == 18) begin
                checkOutput("hold1Pulse", {loopStart, done, converged}, 3'b100);
                checkOutput("hold1Iter", iterCount, 4);
                checkOutput("hold1MaxDiff", maxDiff, 17'h00500);
            end
            if (i == 19) checkOutput("holdReaccept", busy, 1);
            if (i == 36) begin
                checkOutput("hold2Pulse", {loopStart, done, converged}, 3'b011);
                checkOutput("hold2Iter", iterCount, 5);
            end
            if (i == 37) checkOutput("holdConvClears", {busy, converged}, 2'b10);
            if (i == 54) begin
                checkOutput("hold3Pulse", {loopStart, done, converged}, 3'b011);
                checkOutput("hold3Iter", iterCount, 6);
            end
            if (i == 55) checkOutput("holdNoFourth", {busy, loopStart, done}, 0);
        end

        // Reset while idx=8 is in flight.
        alpha = baseAlpha;
        en    = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("midBusy", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstFlags", {busy, loopStart, done, converged}, 0);
        checkOutput("midRstIter", iterCount, 0);
        checkOutput("midRstMaxDiff", maxDiff, 0);
        checkOutput("midRstAlphaSet", alphaSet, 0);
        checkOutput("midRstPolicy", policy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(0, baseAlpha, baseAction, 0);
        checkOutput("postRstLoopDone", {loopStart, done, converged}, 3'b100);
        checkOutput("postRstIter", iterCount, 1);
        checkOutput("postRstMaxDiff", maxDiff, 17'h00FFF);

        // Capped instance: alpha grows each pass, so only the cap can stop it.
        action = baseAction;
        applyStimulus(1, capAlpha1, baseAction, 0);
        checkOutput("cap1Pulse", {loopStartCap, doneCap, convergedCap}, 3'b100);
        applyStimulus(1, capAlpha2, baseAction, 0);
        checkOutput("cap2Pulse", {loopStartCap, doneCap, convergedCap}, 3'b100);
        checkOutput("cap2MaxDiff", maxDiffCap, 17'h01000);
        applyStimulus(1, capAlpha3, baseAction, 0);
        checkOutput("cap3Pulse", {loopStartCap, doneCap, convergedCap}, 3'b010);
        checkOutput("cap3Iter", iterCountCap, 3);
        checkOutput("cap3MaxDiff", maxDiffCap, 17'h01000);
        checkOutput("cap3AlphaSet", alphaSetCap, capAlpha3);
        checkOutput("cap3Policy", policyCap, baseAction);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
